// File: rtl/sif_half_fp_operand_fork_if.sv
// Valid/ready bundle for the FP16 operand fork: one pair stream in, A and B streams out.
// master = producer/consumer side (bench or surrounding logic), slave = the fork itself.
interface sif_half_fp_operand_fork_if #(
   parameter int DW = 16
);
   logic            I_vld;
   logic [2*DW-1:0] I_dat;
   logic            I_sub;
   logic            I_rdy;
   logic            A_vld;
   logic [DW-1:0]   A_dat;
   logic            A_rdy;
   logic            B_vld;
   logic [DW-1:0]   B_dat;
   logic            B_rdy;

   modport master (
      output I_vld, I_dat, I_sub, A_rdy, B_rdy,
      input  I_rdy, A_vld, A_dat, B_vld, B_dat
   );

   modport slave (
      input  I_vld, I_dat, I_sub, A_rdy, B_rdy,
      output I_rdy, A_vld, A_dat, B_vld, B_dat
   );
endinterface

// File: rtl/sif_half_fp_operand_fork.sv
// Forks an FP16 operand pair into independent A/B streams, each behind its own small FIFO.
// B's sign can be flipped on the way in so the downstream adder performs a subtraction.
module sif_half_fp_operand_fork_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_dat,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            cnt_q, cnt_d;

   // Power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];
endmodule

module sif_half_fp_operand_fork #(
   parameter int DW         = 16,
   parameter int FIFO_DEPTH = 2,
   parameter bit EN_SUB     = 1'b1
) (
   input logic                          clk,
   input logic                          rst_n,
   sif_half_fp_operand_fork_if.slave    io
);
   localparam int NB = 2;  // branch 0 = A, branch 1 = B

   logic [NB-1:0][DW-1:0] br_in, br_head;
   logic [NB-1:0]         br_full, br_empty, br_rdy, br_pop;
   logic                  push, flip;
   logic                  init_q, init_d;

   // init_q keeps I_rdy low through reset and rises on the first edge after release.
   always_comb begin
      init_d   = 1'b1;
      flip     = io.I_sub & EN_SUB;
      br_in[0] = io.I_dat[DW-1:0];
      br_in[1] = io.I_dat[2*DW-1:DW] ^ {flip, {(DW-1){1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) init_q <= 1'b0;
      else        init_q <= init_d;
   end

   // I_rdy depends only on registered occupancy, never on A_rdy/B_rdy.
   assign io.I_rdy = init_q & ~|br_full;
   assign push     = io.I_vld & io.I_rdy;
   assign br_rdy   = {io.B_rdy, io.A_rdy};
   assign br_pop   = ~br_empty & br_rdy;

   for (genvar g = 0; g < NB; g++) begin : g_br
      sif_half_fp_operand_fork_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (push),
         .push_dat (br_in[g]),
         .pop      (br_pop[g]),
         .full     (br_full[g]),
         .empty    (br_empty[g]),
         .head     (br_head[g])
      );
   end

   assign io.A_vld = ~br_empty[0];
   assign io.A_dat = br_head[0];
   assign io.B_vld = ~br_empty[1];
   assign io.B_dat = br_head[1];
endmodule
